// File: rtl/piso_serializer.sv
// Parallel-in/serial-out engine for MRAM read data: full or half-word fields,
// configurable bit order, one-deep holding register for gapless streaming.
//
// state | meaning
// IDLE  | shifter empty, waiting for a held word
// SHIFT | presenting bits of the current field on data_out
module piso_serializer #(
    parameter int BUS_WIDTH = 16,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = $clog2(BUS_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    output logic                 load_ready,
    input  logic [1:0]           word_sel,
    input  logic [BUS_WIDTH-1:0] data_in,
    output logic                 data_out,
    output logic                 bit_valid,
    output logic                 bit_last,
    output logic [IDX_W-1:0]     bit_idx,
    output logic                 busy,
    output logic                 sel_err
);

    localparam int HALF = BUS_WIDTH / 2;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [1:0]           hold_sel_q, hold_sel_d;
    logic                 hold_full_q, hold_full_d;
    logic [BUS_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     len_q, len_d;
    logic                 data_out_q, data_out_d;
    logic                 bit_valid_q, bit_valid_d;
    logic                 bit_last_q, bit_last_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 sel_err_q, sel_err_d;

    // Held field normalised so its first-sent bit sits at position 0.
    logic [BUS_WIDTH-1:0] field;
    logic [IDX_W-1:0]     field_last;
    logic                 field_ok;
    logic [IDX_W-1:0]     idx_next;
    logic                 transfer;

    always_comb begin
        field      = '0;
        field_last = '0;
        field_ok   = 1'b1;
        case (hold_sel_q)
            2'b11: begin
                for (int i = 0; i < BUS_WIDTH; i++)
                    field[i] = MSB_FIRST ? hold_data_q[BUS_WIDTH-1-i] : hold_data_q[i];
                field_last = IDX_W'(BUS_WIDTH - 1);
            end
            2'b01: begin
                for (int i = 0; i < HALF; i++)
                    field[i] = MSB_FIRST ? hold_data_q[HALF-1-i] : hold_data_q[i];
                field_last = IDX_W'(HALF - 1);
            end
            2'b10: begin
                for (int i = 0; i < HALF; i++)
                    field[i] = MSB_FIRST ? hold_data_q[BUS_WIDTH-1-i] : hold_data_q[HALF+i];
                field_last = IDX_W'(HALF - 1);
            end
            default: field_ok = 1'b0;
        endcase
    end

    assign idx_next = bit_idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_sel_d  = hold_sel_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        len_d       = len_q;
        data_out_d  = data_out_q;
        bit_valid_d = bit_valid_q;
        bit_last_d  = bit_last_q;
        bit_idx_d   = bit_idx_q;
        sel_err_d   = 1'b0;
        transfer    = 1'b0;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (hold_full_q) transfer = 1'b1;
                end
                SHIFT: begin
                    if (bit_idx_q != len_q) begin
                        data_out_d = shift_q[0];
                        shift_d    = shift_q >> 1;
                        bit_idx_d  = idx_next;
                        bit_last_d = (idx_next == len_q);
                    end else if (hold_full_q) begin
                        transfer = 1'b1;
                    end else begin
                        data_out_d  = 1'b0;
                        bit_valid_d = 1'b0;
                        bit_last_d  = 1'b0;
                        bit_idx_d   = '0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (transfer) begin
                hold_full_d = 1'b0;
                if (field_ok) begin
                    data_out_d  = field[0];
                    shift_d     = field >> 1;
                    len_d       = field_last;
                    bit_idx_d   = '0;
                    bit_valid_d = 1'b1;
                    bit_last_d  = (field_last == '0);
                    state_d     = SHIFT;
                end else begin
                    // Invalid select behaves like a zero-length word.
                    sel_err_d   = 1'b1;
                    data_out_d  = 1'b0;
                    bit_valid_d = 1'b0;
                    bit_last_d  = 1'b0;
                    bit_idx_d   = '0;
                    state_d     = IDLE;
                end
            end

            if (load && load_ready) begin
                hold_data_d = data_in;
                hold_sel_d  = word_sel;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            hold_sel_q  <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            len_q       <= '0;
            data_out_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_last_q  <= 1'b0;
            bit_idx_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_sel_q  <= hold_sel_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            data_out_q  <= data_out_d;
            bit_valid_q <= bit_valid_d;
            bit_last_q  <= bit_last_d;
            bit_idx_q   <= bit_idx_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign load_ready = !hold_full_q && en;
    assign busy       = (state_q == SHIFT) || hold_full_q;
    assign data_out   = data_out_q;
    assign bit_valid  = bit_valid_q;
    assign bit_last   = bit_last_q;
    assign bit_idx    = bit_idx_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer: an LSB-first and an
// MSB-first instance share all stimulus.
module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [1:0]  word_sel = 2'b00;
    logic [15:0] data_in = 16'h0000;

    logic       load_ready, data_out, bit_valid, bit_last, busy, sel_err;
    logic [3:0] bit_idx;
    logic       m_load_ready, m_data_out, m_bit_valid, m_bit_last, m_busy, m_sel_err;
    logic [3:0] m_bit_idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_serializer #(.BUS_WIDTH(16), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_ready(load_ready),
        .word_sel(word_sel), .data_in(data_in), .data_out(data_out),
        .bit_valid(bit_valid), .bit_last(bit_last), .bit_idx(bit_idx),
        .busy(busy), .sel_err(sel_err)
    );

    piso_serializer #(.BUS_WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_ready(m_load_ready),
        .word_sel(word_sel), .data_in(data_in), .data_out(m_data_out),
        .bit_valid(m_bit_valid), .bit_last(m_bit_last), .bit_idx(m_bit_idx),
        .busy(m_busy), .sel_err(m_sel_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [1:0] sel, input logic [15:0] data);
        load = 1'b1;
        word_sel = sel;
        data_in = data;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        step();
        checks++;
        if ({data_out, bit_valid, bit_last, bit_idx, busy, sel_err} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {data_out, bit_valid, bit_last, bit_idx, busy, sel_err}, 9'b0);
        end
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_load_ready got=%b exp=1", load_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        logic [15:0] exp_l = 16'hA5C3;   // LSB-first order is the word itself
        logic [15:0] exp_m = 16'hC3A5;   // bit-reversed A5C3 for MSB-first
        load_word(2'b11, 16'hA5C3);
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL full_latency got valid=%b busy=%b exp valid=0 busy=1", bit_valid, busy);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (data_out !== exp_l[i] || bit_valid !== 1'b1 || bit_idx !== 4'(i)
                || bit_last !== (i == 15)) begin
                failures++;
                $display("FAIL full_lsb bit%0d got d=%b v=%b idx=%0d last=%b exp d=%b v=1 idx=%0d last=%b",
                         i, data_out, bit_valid, bit_idx, bit_last, exp_l[i], i, (i == 15));
            end
            checks++;
            if (m_data_out !== exp_m[i] || m_bit_last !== (i == 15)) begin
                failures++;
                $display("FAIL full_msb bit%0d got d=%b last=%b exp d=%b last=%b",
                         i, m_data_out, m_bit_last, exp_m[i], (i == 15));
            end
        end
        step();
        checks++;
        if (bit_valid !== 1'b0 || bit_last !== 1'b0 || busy !== 1'b0 || data_out !== 1'b0) begin
            failures++;
            $display("FAIL full_end got v=%b last=%b busy=%b d=%b exp all 0",
                     bit_valid, bit_last, busy, data_out);
        end
    endtask

    task automatic test_upper_half();
        logic [7:0] exp_l;
        logic [7:0] exp_m;
        for (int w = 0; w < 2; w++) begin
            exp_l = (w == 0) ? 8'b1000_0001 : 8'b1000_0000;
            exp_m = (w == 0) ? 8'b1000_0001 : 8'b0000_0001;
            load_word(2'b10, (w == 0) ? 16'h8100 : 16'h8000);
            for (int i = 0; i < 8; i++) begin
                step();
                checks++;
                if (data_out !== exp_l[i] || bit_idx !== 4'(i) || bit_last !== (i == 7)
                    || bit_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL upper_lsb w%0d bit%0d got d=%b idx=%0d last=%b v=%b exp d=%b idx=%0d last=%b v=1",
                             w, i, data_out, bit_idx, bit_last, bit_valid, exp_l[i], i, (i == 7));
                end
                checks++;
                if (m_data_out !== exp_m[i] || m_bit_idx !== 4'(i) || m_bit_last !== (i == 7)) begin
                    failures++;
                    $display("FAIL upper_msb w%0d bit%0d got d=%b idx=%0d last=%b exp d=%b idx=%0d last=%b",
                             w, i, m_data_out, m_bit_idx, m_bit_last, exp_m[i], i, (i == 7));
                end
            end
            step();
            checks++;
            if (bit_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL upper_end w%0d got v=%b busy=%b exp v=0 busy=0", w, bit_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        load_word(2'b11, 16'hFFFF);
        step();
        for (int c = 0; c < 32; c++) begin
            exp_rdy = !(c >= 1 && c <= 15);
            checks++;
            if (bit_valid !== 1'b1 || data_out !== (c < 16) || bit_idx !== 4'(c % 16)
                || load_ready !== exp_rdy) begin
                failures++;
                $display("FAIL b2b c%0d got v=%b d=%b idx=%0d rdy=%b exp v=1 d=%b idx=%0d rdy=%b",
                         c, bit_valid, data_out, bit_idx, load_ready, (c < 16), c % 16, exp_rdy);
            end
            if (c == 0) begin
                load = 1'b1;
                word_sel = 2'b11;
                data_in = 16'h0000;
            end
            step();
            load = 1'b0;
        end
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got v=%b busy=%b exp v=0 busy=0", bit_valid, busy);
        end
    endtask

    task automatic test_enable_stall();
        logic [15:0] exp = 16'h00FF;
        load_word(2'b11, 16'h00FF);
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (bit_idx !== 4'd5 || data_out !== 1'b1) begin
            failures++;
            $display("FAIL stall_pre got idx=%0d d=%b exp idx=5 d=1", bit_idx, data_out);
        end
        en = 1'b0;
        load = 1'b1;
        word_sel = 2'b11;
        data_in = 16'hFFFF;
        for (int s = 0; s < 3; s++) begin
            step();
            checks++;
            if (bit_idx !== 4'd5 || data_out !== 1'b1 || bit_valid !== 1'b1 || load_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold s%0d got idx=%0d d=%b v=%b rdy=%b exp idx=5 d=1 v=1 rdy=0",
                         s, bit_idx, data_out, bit_valid, load_ready);
            end
        end
        en = 1'b1;
        load = 1'b0;
        for (int i = 6; i < 16; i++) begin
            step();
            checks++;
            if (bit_idx !== 4'(i) || data_out !== exp[i] || bit_last !== (i == 15)) begin
                failures++;
                $display("FAIL stall_resume bit%0d got idx=%0d d=%b last=%b exp idx=%0d d=%b last=%b",
                         i, bit_idx, data_out, bit_last, i, exp[i], (i == 15));
            end
        end
        step();
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_end got v=%b busy=%b exp v=0 busy=0", bit_valid, busy);
        end
    endtask

    task automatic test_invalid_sel();
        logic [7:0] exp = 8'b0000_0011;
        load_word(2'b00, 16'h1234);
        checks++;
        if (busy !== 1'b1 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL inv_held got busy=%b err=%b exp busy=1 err=0", busy, sel_err);
        end
        step();
        checks++;
        if (sel_err !== 1'b1 || bit_valid !== 1'b0) begin
            failures++;
            $display("FAIL inv_pulse got err=%b v=%b exp err=1 v=0", sel_err, bit_valid);
        end
        step();
        checks++;
        if (sel_err !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL inv_after got err=%b v=%b busy=%b exp all 0", sel_err, bit_valid, busy);
        end
        load_word(2'b01, 16'h0003);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (data_out !== exp[i] || bit_idx !== 4'(i) || bit_last !== (i == 7) || bit_valid !== 1'b1) begin
                failures++;
                $display("FAIL inv_next bit%0d got d=%b idx=%0d last=%b v=%b exp d=%b idx=%0d last=%b v=1",
                         i, data_out, bit_idx, bit_last, bit_valid, exp[i], i, (i == 7));
            end
        end
        step();
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL inv_next_end got v=%b busy=%b exp 0 0", bit_valid, busy);
        end
    endtask

    task automatic test_reset_mid_word();
        load_word(2'b11, 16'hA5C3);
        step();
        load = 1'b1;
        word_sel = 2'b11;
        data_in = 16'h1111;
        step();
        load = 1'b0;
        for (int i = 1; i < 9; i++) step();
        checks++;
        if (bit_idx !== 4'd9 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_pre got idx=%0d rdy=%b exp idx=9 rdy=0", bit_idx, load_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({data_out, bit_valid, bit_last, bit_idx, busy, sel_err} !== 9'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got outs=%b rdy=%b exp outs=%b rdy=1",
                     {data_out, bit_valid, bit_last, bit_idx, busy, sel_err}, load_ready, 9'b0);
        end
        step();
        step();
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_discard got v=%b busy=%b exp v=0 busy=0", bit_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_upper_half();
        test_back_to_back();
        test_enable_stall();
        test_invalid_sel();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
